mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: 32 shift-add or restoring
// shift-subtract steps, then a sign-fix cycle that writes HI/LO.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             hiWrite,
    input  logic             loWrite,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               neg_r_q, neg_r_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_trial;
    logic [2*WIDTH-1:0] mul_next, div_next;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   q_mag, r_mag;

    // op[0] selects unsigned; signed ops work on magnitudes.
    assign a_neg = ~op[0] & operandA[WIDTH-1];
    assign b_neg = ~op[0] & operandB[WIDTH-1];
    assign a_mag = a_neg ? -operandA : operandA;
    assign b_mag = b_neg ? -operandB : operandB;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, m_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // {rem, quo}: shift the next dividend bit into rem, then try to subtract.
    assign div_trial = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]}
                     - {2'b00, m_q};
    assign div_next  = div_trial[WIDTH+1]
                     ? {acc_q[2*WIDTH-2:0], 1'b0}
                     : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign prod_neg = -acc_q;
    assign q_mag    = acc_q[WIDTH-1:0];
    assign r_mag    = acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        m_d      = m_q;
        a_raw_d  = a_raw_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        neg_r_d  = neg_r_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    cnt_d    = '0;
                    is_div_d = op[1];
                    m_d      = op[1] ? b_mag : a_mag;
                    acc_d    = {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
                    a_raw_d  = operandA;
                    neg_d    = a_neg ^ b_neg;
                    neg_r_d  = a_neg;
                    div0_d   = (operandB == '0);
                end else begin
                    if (hiWrite) hi_d = operandA;
                    if (loWrite) lo_d = operandA;
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    {hi_d, lo_d} = neg_q ? prod_neg : acc_q;
                end else if (div0_q) begin
                    hi_d = a_raw_q;
                    lo_d = '1;
                end else begin
                    lo_d = neg_q ? -q_mag : q_mag;
                    hi_d = neg_r_q ? -r_mag : r_mag;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            m_q      <= '0;
            a_raw_q  <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r_q  <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            m_q      <= m_d;
            a_raw_q  <= a_raw_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            neg_r_q  <= neg_r_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
